// File: rtl/maverickOne_pkg.sv
// Shared types and sizing for the maverickOne BTB update path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maverickOne_pkg;

    localparam int XLEN           = 32;
    localparam int NUM_BTBL       = 16;
    localparam int BTB_UPD_QDEPTH = 4;

    // One pending BTB update: resolved branch address and its target.
    typedef struct packed {
        logic [XLEN-1:0] current_addr;
        logic [XLEN-1:0] next_addr;
    } btb_upd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } btb_upd_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending-update queue: storage plus extra-bit read/write pointers, with in-place overwrite of the newest entry.
// Latency: a push is visible on o_head_dat the cycle after it is written.
// Backpressure: none internally; the caller must not push when o_full or pop when o_empty.
module btb_upd_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_ovw,
    input  logic [WIDTH-1:0] i_ovw_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [WIDTH-1:0] o_tail_dat,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_single
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    w_widx;
    logic [AW-1:0]    w_ridx;
    logic [AW-1:0]    w_tidx;
    logic [AW:0]      w_fill;

    assign w_widx = r_wptr[AW-1:0];
    assign w_ridx = r_rptr[AW-1:0];
    assign w_tidx = w_widx - IDX_ONE;
    assign w_fill = r_wptr - r_rptr;

    assign o_head_dat = r_mem[w_ridx];
    assign o_tail_dat = r_mem[w_tidx];
    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);
    assign o_single   = (w_fill == PTR_ONE);

    // Pointer advance; a clear drops every entry at once.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_ONE;
            if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Entry storage; reset to zero so the address outputs read 0 out of reset.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[w_widx] <= i_push_dat;
        end else if (i_ovw) begin
            r_mem[w_tidx] <= i_ovw_dat;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences resolved-branch updates into the BTB write port and sweeps line invalidations on flush.
// Latency: an accepted update reaches btb_* one cycle later at the earliest; a flush sweeps NUM_BTBL cycles.
// Backpressure: upd_ready_o drops when the queue is full, during a sweep, or while flush_i is high.
module btb_update_ctrl #(
    parameter int NUM_BTBL = maverickOne_pkg::NUM_BTBL,
    parameter int XLEN     = maverickOne_pkg::XLEN,
    parameter int QDEPTH   = maverickOne_pkg::BTB_UPD_QDEPTH
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic                        upd_valid_i,
    output logic                        upd_ready_o,
    input  logic [XLEN-1:0]             upd_current_addr_i,
    input  logic [XLEN-1:0]             upd_next_addr_i,
    input  logic                        flush_i,
    output logic                        btb_wr_valid_o,
    input  logic                        btb_wr_ready_i,
    output logic [XLEN-1:0]             btb_current_addr_o,
    output logic [XLEN-1:0]             btb_next_addr_o,
    output logic                        btb_inv_o,
    output logic [$clog2(NUM_BTBL)-1:0] btb_inv_index_o,
    output logic                        busy_o
);

    import maverickOne_pkg::*;

    localparam int IW = $clog2(NUM_BTBL);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BTBL - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    btb_upd_state_e    r_state;
    btb_upd_state_e    w_state_nxt;
    logic [IW-1:0]     r_cnt;
    logic [IW-1:0]     w_cnt_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_single;
    logic              w_acc;
    logic              w_pop;
    logic              w_match;
    logic              w_push;
    logic              w_ovw;
    logic              w_fill_nxt;
    logic [2*XLEN-1:0] w_upd;
    logic [2*XLEN-1:0] w_head;
    logic [2*XLEN-1:0] w_tail;

    assign w_upd = {upd_current_addr_i, upd_next_addr_i};

    assign upd_ready_o    = !w_full && (r_state != FLUSH) && !flush_i;
    assign btb_wr_valid_o = !w_empty && (r_state != FLUSH) && !flush_i;
    assign btb_inv_o      = (r_state == FLUSH) && !flush_i;
    assign btb_inv_index_o = r_cnt;
    assign busy_o         = !w_empty || (r_state == FLUSH);

    assign btb_current_addr_o = w_head[2*XLEN-1:XLEN];
    assign btb_next_addr_o    = w_head[XLEN-1:0];

    assign w_acc = upd_valid_i && upd_ready_o;
    assign w_pop = btb_wr_valid_o && btb_wr_ready_i;

    // A repeat update for the newest queued branch just refreshes its target.
    // If that entry is the head being presented, the BTB simply sees the newer
    // target; only an entry leaving this cycle is off-limits.
    assign w_match = !w_empty
                  && (w_tail[2*XLEN-1:XLEN] == upd_current_addr_i)
                  && !(w_pop && w_single);
    assign w_ovw  = w_acc && w_match;
    assign w_push = w_acc && !w_match;

    assign w_fill_nxt = w_push || (!w_empty && !(w_pop && w_single));

    btb_upd_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .i_clk      (clk_i),
        .i_arst_n   (arst_ni),
        .i_clr      (flush_i),
        .i_push     (w_push),
        .i_push_dat (w_upd),
        .i_ovw      (w_ovw),
        .i_ovw_dat  (w_upd),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_tail_dat (w_tail),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_single   (w_single)
    );

    // Next state and sweep index: flush restarts the sweep from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush_i) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                FLUSH: begin
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + IDX_ONE;
                    end
                end
                default: w_state_nxt = w_fill_nxt ? DRAIN : IDLE;
            endcase
        end
    end

    // State and sweep counter registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios plus random traffic against a queue-level model.
// Latency: checks outputs every cycle half a period after the driving edge.
// Backpressure: randomizes btb_wr_ready_i and flush pulses.
module tb_btb_update_ctrl;

    import maverickOne_pkg::*;

    localparam int NB = NUM_BTBL;
    localparam int QD = BTB_UPD_QDEPTH;

    logic                  clk_i = 1'b0;
    logic                  arst_ni = 1'b0;
    logic                  upd_valid_i = 1'b0;
    logic                  upd_ready_o;
    logic [XLEN-1:0]       upd_current_addr_i = '0;
    logic [XLEN-1:0]       upd_next_addr_i = '0;
    logic                  flush_i = 1'b0;
    logic                  btb_wr_valid_o;
    logic                  btb_wr_ready_i = 1'b0;
    logic [XLEN-1:0]       btb_current_addr_o;
    logic [XLEN-1:0]       btb_next_addr_o;
    logic                  btb_inv_o;
    logic [$clog2(NB)-1:0] btb_inv_index_o;
    logic                  busy_o;

    always #5 clk_i = ~clk_i;

    btb_update_ctrl dut (
        .clk_i              (clk_i),
        .arst_ni            (arst_ni),
        .upd_valid_i        (upd_valid_i),
        .upd_ready_o        (upd_ready_o),
        .upd_current_addr_i (upd_current_addr_i),
        .upd_next_addr_i    (upd_next_addr_i),
        .flush_i            (flush_i),
        .btb_wr_valid_o     (btb_wr_valid_o),
        .btb_wr_ready_i     (btb_wr_ready_i),
        .btb_current_addr_o (btb_current_addr_o),
        .btb_next_addr_o    (btb_next_addr_o),
        .btb_inv_o          (btb_inv_o),
        .btb_inv_index_o    (btb_inv_index_o),
        .busy_o             (busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending updates in order, and the sweep position (-1 = no sweep).
    btb_upd_t mq[$];
    int       m_sweep = -1;

    // Observations collected for scenario-level checks.
    btb_upd_t wr_log[$];
    int       inv_cnt  = 0;
    int       last_inv = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check every output against the model, then advance the model.
    task automatic step(input logic v, input logic [XLEN-1:0] c, input logic [XLEN-1:0] n,
                        input logic r, input logic f);
        logic e_rdy, e_wv, e_inv, acc, pop, coal;
        int   sz;
        @(negedge clk_i);
        upd_valid_i        = v;
        upd_current_addr_i = c;
        upd_next_addr_i    = n;
        btb_wr_ready_i     = r;
        flush_i            = f;
        #1;
        e_rdy = (mq.size() < QD) && (m_sweep < 0) && !f;
        e_wv  = (mq.size() > 0) && (m_sweep < 0) && !f;
        e_inv = (m_sweep >= 0) && !f;
        chk("upd_ready", upd_ready_o, e_rdy);
        chk("wr_valid", btb_wr_valid_o, e_wv);
        chk("inv", btb_inv_o, e_inv);
        chk("busy", busy_o, (mq.size() > 0) || (m_sweep >= 0));
        if (e_wv) begin
            chk("wr_cur", btb_current_addr_o, mq[0].current_addr);
            chk("wr_nxt", btb_next_addr_o, mq[0].next_addr);
        end
        if (e_inv) chk("inv_index", btb_inv_index_o, m_sweep);
        if (btb_wr_valid_o && r) wr_log.push_back({btb_current_addr_o, btb_next_addr_o});
        if (btb_inv_o) begin
            inv_cnt++;
            last_inv = int'(btb_inv_index_o);
        end
        @(posedge clk_i);
        if (f) begin
            mq.delete();
            m_sweep = 0;
        end else begin
            acc  = v && e_rdy;
            pop  = e_wv && r;
            sz   = mq.size();
            coal = acc && (sz > 0) && (mq[sz-1].current_addr == c) && !(pop && sz == 1);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (coal) mq[mq.size()-1].next_addr = n;
                else      mq.push_back({c, n});
            end
            if (m_sweep >= 0) m_sweep = (m_sweep == NB - 1) ? -1 : m_sweep + 1;
        end
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset between clock edges, with the reset-state outputs checked.
    task automatic do_reset();
        @(negedge clk_i);
        #2;
        upd_valid_i    = 1'b0;
        flush_i        = 1'b0;
        btb_wr_ready_i = 1'b0;
        arst_ni        = 1'b0;
        #1;
        chk("rst_upd_ready", upd_ready_o, 1);
        chk("rst_wr_valid", btb_wr_valid_o, 0);
        chk("rst_inv", btb_inv_o, 0);
        chk("rst_inv_index", btb_inv_index_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cur", btb_current_addr_o, 0);
        chk("rst_nxt", btb_next_addr_o, 0);
        mq.delete();
        m_sweep = -1;
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    initial begin
        int n0, i0;
        logic [XLEN-1:0] pool [6];

        do_reset();

        // Single update into an empty queue with the BTB ready.
        n0 = wr_log.size();
        step(1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
        idle(2);
        chk("t1_writes", wr_log.size() - n0, 1);
        chk("t1_cur", wr_log[n0].current_addr, 32'h100);
        chk("t1_nxt", wr_log[n0].next_addr, 32'h200);

        // Fill the queue while the BTB stalls, then drain in order.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h1000 + 32'(16 * i), 32'h2000 + 32'(16 * i), 1'b0, 1'b0);
        step(1'b1, 32'h5000, 32'h6000, 1'b0, 1'b0);
        n0 = wr_log.size();
        idle(4);
        chk("t2_writes", wr_log.size() - n0, 4);
        for (int i = 0; i < 4; i++) begin
            if (n0 + i < wr_log.size()) begin
                chk("t2_order_cur", wr_log[n0+i].current_addr, 32'h1000 + 32'(16 * i));
                chk("t2_order_nxt", wr_log[n0+i].next_addr, 32'h2000 + 32'(16 * i));
            end
        end
        idle(1);

        // Back-to-back updates for the same branch collapse into one write.
        step(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h100, 32'h300, 1'b0, 1'b0);
        n0 = wr_log.size();
        idle(3);
        chk("t3_writes", wr_log.size() - n0, 1);
        chk("t3_nxt", wr_log[n0].next_addr, 32'h300);

        // Flush with two entries queued: full sweep, queue discarded.
        step(1'b1, 32'h700, 32'h710, 1'b0, 1'b0);
        step(1'b1, 32'h800, 32'h810, 1'b0, 1'b0);
        n0 = wr_log.size();
        i0 = inv_cnt;
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(NB + 3);
        chk("t4_inv_cycles", inv_cnt - i0, NB);
        chk("t4_writes", wr_log.size() - n0, 0);
        chk("t4_last_index", last_inv, NB - 1);

        // Second flush part-way through a sweep restarts it from index 0.
        last_inv = -1;
        i0 = inv_cnt;
        step(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < NB && last_inv != 3; k++) idle(1);
        chk("t5_reached_idx3", last_inv, 3);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(NB + 3);
        chk("t5_inv_cycles", inv_cnt - i0, NB + 4);

        // Reset during a sweep abandons it for good.
        last_inv = -1;
        step(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < NB && last_inv != 2; k++) idle(1);
        chk("t6_reached_idx2", last_inv, 2);
        do_reset();
        i0 = inv_cnt;
        idle(NB + 4);
        chk("t6_no_inv_after_reset", inv_cnt - i0, 0);

        // Random traffic from a small address pool so coalescing happens often.
        for (int i = 0; i < 6; i++) pool[i] = 32'h4000 + 32'(i * 4);
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)),
                 pool[$urandom_range(0, 5)],
                 32'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 79) == 0));
        end
        idle(NB + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
